// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 10-bit frame, ack.
// Build option: define PS2_HOST_TX_ACK_CHECK_EN to turn a high data line at the ack clock into tx_err.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6500,
  parameter int TIMEOUT_CYCLES = 1300000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  // state    | meaning
  // IDLE     | lines released, waiting for tx_start
  // INHIBIT  | clock held low; data also pulled low in the last cycle
  // REQ      | clock released, start bit (data low) on the line
  // SHIFT    | data bits, parity, stop presented one per device falling edge
  // ACK      | data released, device ack sampled on the next falling edge

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_HOST_TX_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK} state_t;

  state_t        state;
  logic [1:0]    clk_sync;
  logic          clk_prev;
  logic [1:0]    data_sync;
  logic [9:0]    frame;
  logic [3:0]    bit_idx;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic          fe;
  logic [3:0]    next_idx;

  assign fe       = clk_prev & ~clk_sync[1];
  assign next_idx = bit_idx + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      clk_sync    <= 2'b11;
      clk_prev    <= 1'b1;
      data_sync   <= 2'b11;
      frame       <= '0;
      bit_idx     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      clk_prev  <= clk_sync[1];
      data_sync <= {data_sync[0], ps2_data_in};
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;

      case (state)
        IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          busy        <= 1'b0;
          // busy is still high in the cycle of a done/err pulse, so a start there is dropped
          if (tx_start && !busy) begin
            frame       <= {1'b1, ~^tx_data, tx_data};
            busy        <= 1'b1;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= (INHIBIT_CYCLES == 1);
            inh_cnt     <= IW'(INHIBIT_CYCLES - 1);
            state       <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (inh_cnt == '0) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            to_cnt      <= '0;
            state       <= REQ;
          end else begin
            inh_cnt <= inh_cnt - IW'(1);
            if (inh_cnt == IW'(1)) ps2_data_oe <= 1'b1;
          end
        end

        REQ, SHIFT, ACK: begin
          if (fe) begin
            to_cnt <= '0;
            case (state)
              REQ: begin
                bit_idx     <= '0;
                ps2_data_oe <= ~frame[0];
                state       <= SHIFT;
              end
              SHIFT: begin
                if (bit_idx == 4'd9) begin
                  ps2_data_oe <= 1'b0;
                  state       <= ACK;
                end else begin
                  bit_idx     <= next_idx;
                  ps2_data_oe <= ~frame[next_idx];
                end
              end
              default: begin
                if (ACK_CHECK && data_sync[1]) tx_err <= 1'b1;
                else                           tx_done <= 1'b1;
                state <= IDLE;
              end
            endcase
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_err      <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have these parameters:
- INHIBIT_CYCLES, default 6500: host clock-low hold before start; 100 us at 65 MHz.
- TIMEOUT_CYCLES, default 1300000: maximum gap between device clock falling edges; 20 ms.
REQ-003 The block SHALL have these ports (clock and reset first):
- clk  in  1: 65 MHz pixel/system clock.
- rst  in  1: synchronous active-high reset.
- tx_data  in  8: command byte to send to the PS/2 device.
- tx_start  in  1: single-cycle send request.
- ps2_clk_in  in  1: raw PS/2 clock line readback (asynchronous).
- ps2_data_in  in  1: raw PS/2 data line readback (asynchronous).
- ps2_clk_oe  out  1: 1 = drive the PS/2 clock line low; 0 = release it.
- ps2_data_oe  out  1: 1 = drive the PS/2 data line low; 0 = release it.
- busy  out  1: transaction in progress.
- tx_done  out  1: one-cycle pulse on successful completion.
- tx_err  out  1: one-cycle pulse on a failed transaction (timeout or missing ack).

Function
REQ-004 The block SHALL pass ps2_clk_in and ps2_data_in through 2-flop synchronizers; a falling edge (fe) SHALL be synchronized previous = 1 and synchronized current = 0.
REQ-005 States SHALL be IDLE, INHIBIT, REQ, SHIFT, ACK.
REQ-006 In IDLE with tx_start = 1, the block SHALL latch tx_data, compute the odd-parity bit (~^tx_data), set busy on the next cycle, and go to INHIBIT.
REQ-007 A tx_start asserted while busy = 1 SHALL be ignored, with no queuing.
REQ-008 In INHIBIT, ps2_clk_oe SHALL be 1 for exactly INHIBIT_CYCLES cycles, and ps2_data_oe SHALL also be 1 during the final cycle; the block SHALL then go to REQ.
REQ-009 In REQ, ps2_clk_oe SHALL be 0 and ps2_data_oe SHALL be 1 (start bit); the first fe SHALL enter SHIFT with bit index 0.
REQ-010 In SHIFT, on each fe the block SHALL present the next frame bit: data[0..7] LSB first, then parity, then stop (1).
REQ-011 Bit values SHALL map to the line as follows: bit = 0 means ps2_data_oe = 1; bit = 1 means ps2_data_oe = 0.
REQ-012 Each bit value SHALL be held until the next fe.
REQ-013 After the stop bit is presented, the next fe SHALL enter ACK with ps2_data_oe = 0.
REQ-014 In ACK, the block SHALL sample the synchronized data line on the next fe and then return to IDLE.
REQ-015 A 4-bit bit index SHALL count 0..9 in SHIFT and SHALL never wrap.
REQ-016 A timeout counter SHALL clear on every fe and on entry to REQ, and SHALL count in REQ, SHIFT and ACK.
REQ-017 When the timeout counter reaches TIMEOUT_CYCLES, the block SHALL release both lines, pulse tx_err, and return to IDLE.
REQ-018 A timeout in the same cycle as an fe SHALL give the fe priority.
REQ-019 In IDLE, both oe outputs SHALL be 0 and busy SHALL be 0.
REQ-020 busy SHALL be 1 from the cycle after acceptance until the cycle tx_done or tx_err pulses, inclusive.
REQ-021 tx_done and tx_err SHALL never assert in the same cycle, and neither SHALL assert for more than one cycle.

Reset
REQ-022 While rst = 1 at a clock edge, the block SHALL set the state to IDLE, set all outputs to 0, and clear the counters, the latched byte and the synchronizers to 1 (idle line).
REQ-023 A reset mid-transaction SHALL release both lines at the next clock edge and SHALL produce no tx_done or tx_err pulse.

Configuration
REQ-024 Macro PS2_HOST_TX_ACK_CHECK_EN SHALL control acknowledge checking.
- Defined: in ACK, sampled data = 0 SHALL pulse tx_done; sampled data = 1 SHALL pulse tx_err.
- Undefined: tx_done SHALL pulse on the ACK fe regardless of the data line; tx_err SHALL come from timeout only.

Verification
REQ-025 Send 0xF4 with a device model clocking at 12.5 kHz and acking -> clk held low for 6500 cycles, start bit 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1, tx_done pulse, busy low afterwards.
REQ-026 Send 0xED -> parity bit 1; send 0x00 -> parity bit 1; the device model captures both bytes exactly.
REQ-027 Device never clocks after REQ -> tx_err pulses 1300000 cycles after REQ entry, both oe = 0, state IDLE.
REQ-028 With the macro defined, the device leaves data high at the ack clock -> tx_err pulse, no tx_done; the same stimulus with the macro undefined -> tx_done.
REQ-029 Pulse tx_start again during SHIFT with tx_data = 0xFF -> ignored, the original byte completes unchanged.
REQ-030 Assert rst after 4 data bits -> next cycle: oe = 00, busy = 0, no pulses; a following tx_start of 0xF4 completes normally.
